// File: rtl/fpu_arbiter.sv
// Shares one registered-output FPU among NREQ requesters with a valid/ready
// request side and a tagged response. FPU_ARB_RR_EN selects round-robin arbitration.
module fpu_arbiter #(
   parameter int NREQ    = 4,
   parameter int OP_LAT  = 2,
   parameter int DIV_LAT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [31:0]          fpu_a,
   output logic [31:0]          fpu_b,
   output logic [1:0]           fpu_opcode,
   input  logic [31:0]          fpu_o,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [1:0]           rsp_id,
   output logic [31:0]          rsp_data,
   output logic                 busy
);

   localparam int MAX_LAT = (DIV_LAT > OP_LAT) ? DIV_LAT : OP_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] OP_DIV  = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [1:0]       id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
`ifdef FPU_ARB_RR_EN
   logic [1:0]       rr_q, rr_d;
`endif

   logic             gnt_valid;
   logic [1:0]       gnt_idx;
   logic [1:0]       sel_op;
   logic [31:0]      sel_a, sel_b;
   logic [3:0]       valid4, ready4;
   logic [1:0]       idx;
   int               start;

   // Search from the start index; iterating downwards lets the nearest hit win.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      gnt_valid = 1'b0;
      gnt_idx   = 2'd0;
      idx       = 2'd0;
      valid4    = 4'(req_valid);
`ifdef FPU_ARB_RR_EN
      start = int'(rr_q);
`else
      start = 0;
`endif
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = 2'((start + k) % NREQ);
         if (valid4[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
      sel_op = 2'd0;
      sel_a  = 32'd0;
      sel_b  = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == 2'(i)) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[32*i +: 32];
            sel_b  = req_b[32*i +: 32];
         end
      end
      ready4 = 4'd0;
      if (state_q == ST_IDLE && !rst && gnt_valid) ready4[gnt_idx] = 1'b1;
      req_ready = ready4[NREQ-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
`ifdef FPU_ARB_RR_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               op_d    = sel_op;
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = gnt_idx;
               cnt_d   = (sel_op == OP_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(OP_LAT - 1);
               state_d = ST_EXEC;
`ifdef FPU_ARB_RR_EN
               rr_d    = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
`endif
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               rsp_data_d  = fpu_o;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            // Returning to IDLE first keeps a grant out of the handshake cycle.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= 2'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         id_q        <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
`ifdef FPU_ARB_RR_EN
         rr_q        <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
`ifdef FPU_ARB_RR_EN
         rr_q        <= rr_d;
`endif
      end
   end

   assign fpu_a      = a_q;
   assign fpu_b      = b_q;
   assign fpu_opcode = op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model and a behavioural FPU.
module tb_fpu_arbiter;
   localparam int NREQ    = 4;
   localparam int OP_LAT  = 2;
   localparam int DIV_LAT = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid, req_ready;
   logic [2*NREQ-1:0]    req_op;
   logic [32*NREQ-1:0]   req_a, req_b;
   logic [31:0]          fpu_a, fpu_b, fpu_o, rsp_data;
   logic [1:0]           fpu_opcode, rsp_id;
   logic                 rsp_valid, rsp_ready, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fpu_arbiter #(.NREQ(NREQ), .OP_LAT(OP_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   // ---------------- behavioural FPU (normal numbers, truncating) ----------------
   function automatic real sp2r(logic [31:0] x);
      logic [10:0] e;
      if (x[30:23] == 8'd0) return 0.0;
      e = {3'b000, x[30:23]} + 11'd896;
      return $bitstoreal({x[31], e, x[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2sp(real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      e = d[62:52];
      if (e < 11'd897) return {d[63], 31'd0};
      if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
      e = e - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
      case (op)
         2'b00:   return r2sp(sp2r(a) + sp2r(b));
         2'b01:   return r2sp(sp2r(a) - sp2r(b));
         2'b10:   return r2sp(sp2r(a) / sp2r(b));
         default: return r2sp(sp2r(a) * sp2r(b));
      endcase
   endfunction

   always @(posedge clk) fpu_o <= fpu_fn(fpu_a, fpu_b, fpu_opcode);

   // ---------------- transaction-level reference model ----------------
   bit          m_busy, m_resp;
   int          m_id, m_age, m_rr;
   logic [31:0] m_a, m_b, m_data;
   logic [1:0]  m_op;

   function automatic int pick(logic [NREQ-1:0] v, int start);
      logic [3:0] v4;
      v4 = 4'(v);
      for (int k = 0; k < NREQ; k++)
         if (v4[2'((start + k) % NREQ)]) return (start + k) % NREQ;
      return -1;
   endfunction

   function automatic int search_start();
`ifdef FPU_ARB_RR_EN
      return m_rr;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      int g;
      if (rst) begin
         m_busy = 0; m_resp = 0; m_id = 0; m_age = 0; m_rr = 0;
         m_a = '0; m_b = '0; m_op = '0; m_data = '0;
      end else if (!m_busy) begin
         g = pick(req_valid, search_start());
         if (g >= 0) begin
            m_busy = 1; m_id = g; m_age = 0;
            m_a  = req_a[32*g +: 32];
            m_b  = req_b[32*g +: 32];
            m_op = req_op[2*g +: 2];
            m_rr = (g + 1) % NREQ;
         end
      end else if (!m_resp) begin
         m_age++;
         if (m_age == ((m_op == 2'b10) ? DIV_LAT : OP_LAT)) begin
            m_resp = 1;
            m_data = fpu_fn(m_a, m_b, m_op);
         end
      end else if (rsp_ready) begin
         m_busy = 0;
         m_resp = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      logic [3:0] exp_rdy;
      int g;
      exp_rdy = 4'd0;
      if (!m_busy && !rst) begin
         g = pick(req_valid, search_start());
         if (g >= 0) exp_rdy[2'(g)] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy[NREQ-1:0]));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      check("fpu_a", fpu_a, m_a);
      check("fpu_b", fpu_b, m_b);
      check("fpu_opcode", 32'(fpu_opcode), 32'(m_op));
      if (m_resp) begin
         check("rsp_id", 32'(rsp_id), 32'(m_id));
         check("rsp_data", rsp_data, m_data);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid[i]       = 1'b1;
      req_op[2*i +: 2]   = op;
      req_a[32*i +: 32]  = a;
      req_b[32*i +: 32]  = b;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) timeout_fail("wait_idle");
   endtask

   task automatic wait_rsp(output int id, output logic [31:0] data);
      bit ok = 0;
      id = -1; data = '0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            id = int'(rsp_id); data = rsp_data; ok = 1; break;
         end
      end
      if (!ok) timeout_fail("wait_rsp");
   endtask

   // Counts edges from the handshake edge (just passed) to the first visible rsp_valid.
   task automatic measure_latency(output int lat);
      lat = -1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = j - 1; break; end
      end
      if (lat < 0) timeout_fail("latency");
   endtask

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(1)), 8'($urandom_range(130, 124)), 23'($urandom)};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int id, lat;
      int exp_order[5];
      logic [31:0] data;
      logic [NREQ-1:0] hs;

`ifdef FPU_ARB_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif

      // Reset, with all four requesters already asserting.
      rst = 1'b1;
      rsp_ready = 1'b1;
      clear_reqs();
      for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'h3F800000, 32'h40000000);
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", rsp_data, 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_fpu_a", fpu_a, 32'd0);
      check("reset_fpu_opcode", 32'(fpu_opcode), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      step();
      rst = 1'b0;

      // Contention: five responses in arbitration order.
      for (int n = 0; n < 5; n++) begin
         wait_rsp(id, data);
         check("contention_id", 32'(id), 32'(exp_order[n]));
         check("contention_data", data, 32'h40400000);
      end
      step();
      clear_reqs();
      wait_idle();

      // ADD, no contention.
      step();
      set_req(0, 2'b00, 32'h3F800000, 32'h40000000);
      @(negedge clk);
      check("add_ready", 32'(req_ready), 32'h1);
      step();
      clear_reqs();
      measure_latency(lat);
      check("add_latency", 32'(lat), 32'd2);
      check("add_id", 32'(rsp_id), 32'd0);
      check("add_data", rsp_data, 32'h40400000);
      wait_idle();

      // MUL with five cycles of backpressure and a competing request.
      rsp_ready = 1'b0;
      step();
      set_req(1, 2'b11, 32'h40000000, 32'h40400000);
      @(negedge clk);
      check("mul_ready", 32'(req_ready), 32'h2);
      step();
      clear_reqs();
      set_req(0, 2'b00, 32'h3F800000, 32'h3F800000);
      measure_latency(lat);
      check("mul_latency", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         check("mul_bp_valid", 32'(rsp_valid), 32'd1);
         check("mul_bp_data", rsp_data, 32'h40C00000);
         check("mul_bp_id", 32'(rsp_id), 32'd1);
         check("mul_bp_busy", 32'(busy), 32'd1);
         check("mul_bp_ready", 32'(req_ready), 32'd0);
         check("mul_bp_fpu_a", fpu_a, 32'h40000000);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("mul_hs_no_grant", 32'(req_ready), 32'd0);
      step();
      clear_reqs();
      wait_idle();

      // DIV latency and operand stability.
      step();
      set_req(2, 2'b10, 32'h40C00000, 32'h40000000);
      @(negedge clk);
      check("div_ready", 32'(req_ready), 32'h4);
      step();
      clear_reqs();
      lat = -1;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = j - 1; break; end
         check("div_fpu_a", fpu_a, 32'h40C00000);
         check("div_fpu_b", fpu_b, 32'h40000000);
         check("div_fpu_op", 32'(fpu_opcode), 32'h2);
      end
      if (lat < 0) timeout_fail("div_latency");
      check("div_latency", 32'(lat), 32'd4);
      check("div_id", 32'(rsp_id), 32'd2);
      check("div_data", rsp_data, 32'h40400000);
      wait_idle();

      // Reset in the second EXEC cycle of a DIV.
      step();
      set_req(2, 2'b10, 32'h40C00000, 32'h40000000);
      step();
      clear_reqs();
      step();
      rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_fpu_a", fpu_a, 32'd0);
      check("rst_fpu_b", fpu_b, 32'd0);
      check("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      step();
      set_req(3, 2'b00, 32'h3F800000, 32'h3F800000);
      set_req(0, 2'b00, 32'h3F800000, 32'h40000000);
      @(negedge clk);
      check("rst_next_grant", 32'(req_ready), 32'h1);
      step();
      clear_reqs();
      wait_idle();

      // Randomized traffic, checked by the per-cycle compare process.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || hs[i]) begin
               if ($urandom_range(99) < 35)
                  set_req(i, 2'($urandom_range(3)), rand_fp(), rand_fp());
               else
                  req_valid[i] = 1'b0;
            end else if ($urandom_range(99) < 3) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(99) < 70);
      end
      step();
      clear_reqs();
      rsp_ready = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one `fpu` instance (ADD/SUB/DIV/MUL, registered output) among up to four requesters. Each requester sees a valid/ready request port and a tagged response port. The block selects a requester, holds the operands stable on the FPU for the opcode's cycle budget, captures the result, and returns it with the requester's index. It sits between the requesting engines and the FPU, and is the only driver of the FPU's `A`, `B` and `opcode` inputs.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..4.
- `OP_LAT`, default 2: cycle budget for ADD/SUB/MUL, minimum 2.
- `DIV_LAT`, default 4: cycle budget for DIV, minimum 2. The reciprocal chain is long, so this is larger.
- `clk` in 1: rising-edge clock, shared with `fpu`.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester grant. One-hot or zero.
- `req_op` in 2*NREQ: opcode of requester i at bits [2i+1:2i]. 00 ADD, 01 SUB, 10 DIV, 11 MUL.
- `req_a` in 32*NREQ: operand A of requester i at bits [32i+31:32i].
- `req_b` in 32*NREQ: operand B of requester i, same packing as `req_a`.
- `fpu_a`, `fpu_b` out 32: operands driven to the FPU.
- `fpu_opcode` out 2: opcode driven to the FPU.
- `fpu_o` in 32: FPU result.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out 2: index of the requester that owns the response.
- `rsp_data` out 32: IEEE-754 single-precision result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Three states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is combinational and is nonzero only in IDLE.
  - If any `req_valid` is high, the arbiter picks a grant index g and drives `req_ready[g]=1`.
  - On that edge the block latches op, A, B and g, loads `cnt` (DIV → DIV_LAT-1, otherwise OP_LAT-1), and moves to EXEC.
  - With no `req_valid` high, the state stays IDLE.
- **EXEC**
  - `fpu_a`, `fpu_b` and `fpu_opcode` come from the latched registers and are constant for the whole operation.
  - `cnt` decrements every cycle.
  - On the edge where `cnt==0`, the block captures `fpu_o` into `rsp_data`, sets `rsp_valid`, and moves to RESP.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_valid & rsp_ready`.
  - On that handshake, the next state is IDLE and `rsp_valid` drops.
  - There is no grant in the same cycle as the handshake.
- **Arbitration**
  - Round-robin pointer `rr` (2 bits). The search starts at `rr`, covers indices `rr, rr+1, ...` modulo NREQ, and the first index with `req_valid` high wins.
  - On a grant, `rr` becomes (g+1) mod NREQ.
  - Indices at or above NREQ are never granted.
- The block does no special-case or NaN handling. `fpu` owns that, and the result is passed through unmodified.
- `req_valid` must stay asserted with stable fields until `req_ready`. Withdrawing a request before its grant is allowed, and the block ignores it.

## Timing
- **Reset values:** state=IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rr`=0, `fpu_a`=0, `fpu_b`=0, `fpu_opcode`=0, `busy`=0, `req_ready`=0.
- **Latency:** for a request handshake at edge k, `rsp_valid` is high from edge k+OP_LAT, or k+DIV_LAT for DIV.
- **Throughput:** at most one operation is in flight. With zero backpressure, the minimum spacing between grants is LAT+2 cycles.
- **Backpressure:** each cycle `rsp_ready` stays low extends RESP by one cycle. The FPU inputs keep their last values during this time.
- **Reset mid-operation:** `rst` clears everything immediately, at any state.
  - An operation in EXEC or RESP is dropped and no response is produced.
  - The requester has already seen its handshake and must reissue.
- **Simultaneous requests:** all NREQ requesters asserting together are served in the order rr, rr+1, and so on. No requester waits more than NREQ-1 operations.
- **Requester with no partner:** a requester that is alone is granted on every IDLE visit.

## Configuration
- `FPU_ARB_RR_EN`
  - **Defined:** round-robin arbitration as described under Operation.
  - **Undefined:** fixed priority. The lowest asserted index wins, and the `rr` register is removed. Low indices can starve high ones, and this is accepted in that build.

## Test plan
- **ADD, no contention:** req0 ADD A=0x3F800000, B=0x40000000 at edge k → `rsp_valid` at edge k+2, `rsp_id`=0, `rsp_data`=0x40400000.
- **MUL with backpressure:** req1 MUL 0x40000000 × 0x40400000, `rsp_ready` low for 5 cycles → `rsp_data`=0x40C00000 held stable throughout; `busy` high; no `req_ready` asserted during that time.
- **DIV latency:** req2 DIV 0x40C00000 / 0x40000000 → `rsp_valid` at edge k+4; `rsp_data` equals the `fpu_o` value sampled at the capture edge (nominally 0x40400000); `fpu_a`/`fpu_b` constant over the 4 cycles.
- **Contention, round-robin build:** all four `req_valid` held high from reset → grant order 0,1,2,3,0; `rsp_id` sequence matches.
- **Contention, fixed-priority build:** the same stimulus without `FPU_ARB_RR_EN` → every grant goes to index 0.
- **Reset mid-operation:** `rst` asserted in the second EXEC cycle of a DIV → all outputs at reset values immediately; no `rsp_valid` follows; the next grant goes to index 0.
